// File: rtl/tbird_seq.sv
// Thunderbird tail-light sequencer: synchronizes turn/hazard requests and steps a
// light pattern FSM once per prescaler tick, driving an active-low 22-bit VGA code.
module tbird_seq #(
  parameter int TICK_DIV = 12500000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        left,
  input  logic        right,
  input  logic        hazard,
  output logic [21:0] vga_in,
  output logic        tick,
  output logic [3:0]  seq_state
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    L1      = 4'd1,
    L2      = 4'd2,
    L3      = 4'd3,
    L4      = 4'd4,
    L5      = 4'd5,
    R1      = 4'd6,
    R2      = 4'd7,
    R3      = 4'd8,
    R4      = 4'd9,
    R5      = 4'd10,
    HAZ_ON  = 4'd11,
    HAZ_OFF = 4'd12
  } state_t;

  logic [2:0]    meta_q;
  logic [2:0]    sync_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  state_t        state_q;
  state_t        state_d;
  logic [21:0]   vga_q;
  logic          left_s;
  logic          right_s;
  logic          hazard_s;
  logic          haz_req;

  assign {hazard_s, left_s, right_s} = sync_q;
  assign haz_req = hazard_s | (left_s & right_s);

  function automatic logic [21:0] lit_bits(input state_t s);
    logic [21:0] b;
    b = '0;
    case (s)
      L1:      b[12:11] = '1;
      L2:      b[15:11] = '1;
      L3:      b[18:11] = '1;
      L4:      b[20:11] = '1;
      L5:      b[21:11] = '1;
      R1:      b[10:9]  = '1;
      R2:      b[10:6]  = '1;
      R3:      b[10:3]  = '1;
      R4:      b[10:1]  = '1;
      R5:      b[10:0]  = '1;
      HAZ_ON:  b        = '1;
      default: b        = '0;
    endcase
    return b;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= {hazard, left, right};
      sync_q <= meta_q;
    end
  end

  assign tick  = (cnt_q == CW'(TICK_DIV - 1));
  assign cnt_d = tick ? '0 : cnt_q + CW'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, L1, L2, L3, L4, L5, R1, R2, R3, R4, R5, HAZ_ON, HAZ_OFF: begin
        if (tick) begin
          if (haz_req) begin
            state_d = (state_q == HAZ_ON) ? HAZ_OFF : HAZ_ON;
          end else if (left_s) begin
            if (state_q == L5)
              state_d = IDLE;
            else if (state_q >= L1 && state_q <= L4)
              state_d = state_t'(state_q + 4'd1);
            else
              state_d = L1;
          end else if (right_s) begin
            if (state_q == R5)
              state_d = IDLE;
            else if (state_q >= R1 && state_q <= R4)
              state_d = state_t'(state_q + 4'd1);
            else
              state_d = R1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      // Codes 13-15 recover to IDLE without waiting for a tick.
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      vga_q   <= '1;
    end else begin
      state_q <= state_d;
      vga_q   <= ~lit_bits(state_d);
    end
  end

  assign vga_in    = vga_q;
  assign seq_state = state_q;

endmodule

// File: tb/tb_tbird_seq.sv
// Randomized bench for tbird_seq (TICK_DIV=4) against a direction/step reference model.
module tb_tbird_seq;

  logic        clk;
  logic        reset;
  logic        left;
  logic        right;
  logic        hazard;
  logic [21:0] vga_in;
  logic        tick;
  logic [3:0]  seq_state;

  int n_cmp;
  int n_bad;

  tbird_seq #(.TICK_DIV(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .left      (left),
    .right     (right),
    .hazard    (hazard),
    .vga_in    (vga_in),
    .tick      (tick),
    .seq_state (seq_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: dir 0=idle 1=left 2=right 3=hazard-on 4=hazard-off; step 1..5 for turns.
  int       m_dir;
  int       m_step;
  int       m_cnt;
  logic [2:0] m_hist[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [21:0] exp_vga();
    int tops[5] = '{12, 15, 18, 20, 21};
    int los[5]  = '{9, 6, 3, 1, 0};
    longint lit;
    lit = 0;
    if (m_dir == 1) lit = (64'd1 << (tops[m_step-1] + 1)) - (64'd1 << 11);
    else if (m_dir == 2) lit = (64'd1 << 11) - (64'd1 << los[m_step-1]);
    else if (m_dir == 3) lit = 64'h3FFFFF;
    return ~lit[21:0];
  endfunction

  function automatic logic [3:0] exp_code();
    case (m_dir)
      1: return 4'(m_step);
      2: return 4'(5 + m_step);
      3: return 4'd11;
      4: return 4'd12;
      default: return 4'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_dir = 0;
    m_step = 0;
    m_cnt = 0;
    m_hist = '{3'b000, 3'b000};
  endtask

  // Applies one rising edge; requests reach decisions two edges after sampling.
  task automatic model_edge();
    logic [2:0] r;
    r = m_hist.pop_front();
    m_hist.push_back({hazard, left, right});
    if (m_cnt == 3) begin
      if (r[2] || (r[1] && r[0])) begin
        m_dir = (m_dir == 3) ? 4 : 3;
        m_step = 0;
      end else if (r[1]) begin
        if (m_dir == 1 && m_step < 5) m_step++;
        else if (m_dir == 1) begin m_dir = 0; m_step = 0; end
        else begin m_dir = 1; m_step = 1; end
      end else if (r[0]) begin
        if (m_dir == 2 && m_step < 5) m_step++;
        else if (m_dir == 2) begin m_dir = 0; m_step = 0; end
        else begin m_dir = 2; m_step = 1; end
      end else begin
        m_dir = 0;
        m_step = 0;
      end
    end
    m_cnt = (m_cnt + 1) % 4;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    chk("vga_in", 32'(vga_in), 32'(exp_vga()));
    chk("seq_state", 32'(seq_state), 32'(exp_code()));
    chk("tick", 32'(tick), 32'(m_cnt == 3));
  endtask

  // Entered just after a rising edge; reset must clear outputs with no clock edge.
  task automatic reset_pulse();
    #2 reset = 1'b1;
    #1;
    chk("rst_vga", 32'(vga_in), 32'h3FFFFF);
    chk("rst_state", 32'(seq_state), 32'd0);
    chk("rst_tick", 32'(tick), 32'd0);
    model_reset();
    @(posedge clk);
    #3 reset = 1'b0;
  endtask

  initial begin
    int pat;
    int len;
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    left = 1'b0;
    right = 1'b0;
    hazard = 1'b0;
    model_reset();
    #2;
    chk("init_vga", 32'(vga_in), 32'h3FFFFF);
    chk("init_state", 32'(seq_state), 32'd0);
    chk("init_tick", 32'(tick), 32'd0);
    @(posedge clk);
    #3 reset = 1'b0;

    for (int i = 0; i < 20; i++) cycle();

    for (int seg = 0; seg < 80; seg++) begin
      pat = $urandom_range(0, 6);
      case (pat)
        0: {hazard, left, right} = 3'b000;
        1: {hazard, left, right} = 3'b010;
        2: {hazard, left, right} = 3'b001;
        3: {hazard, left, right} = 3'b011;
        4: {hazard, left, right} = 3'b100;
        5: {hazard, left, right} = 3'b110;
        default: {hazard, left, right} = 3'($urandom_range(0, 7));
      endcase
      len = (pat == 1 || pat == 2) ? $urandom_range(4, 30) : $urandom_range(1, 16);
      for (int c = 0; c < len; c++) cycle();
      if ($urandom_range(0, 7) == 0) reset_pulse();
    end

    {hazard, left, right} = 3'b001;
    for (int c = 0; c < 16; c++) cycle();
    reset_pulse();
    {hazard, left, right} = 3'b000;
    for (int c = 0; c < 8; c++) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
